id_stage: RTL and testbench

- Decode stage of the 5-stage pipelined MIPS core; it is the consumer of the IF/ID pipeline register.
- Receives PC, PC+4 and the instruction from the fetch stage.
- Resolves beq/bne/j/jal/jr in ID and returns branch/jump requests and target addresses to fetch.
- Drives GRF read addresses and owns the ID/EX pipeline register, with stall-driven bubble insertion.

---
 rtl/id_stage_pkg.sv | 17 +
 rtl/id_stage_ext.sv | 12 +
 rtl/id_stage.sv | 97 +++++++++
 tb/tb_id_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared CPU constants (opcodes, funct codes, reset PC, link register) and extender ops
package id_stage_pkg;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [4:0] RA_REG = 5'd31;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] FUNCT_JR = 6'b001000;
   typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} ext_op_e;
endpackage

// File: rtl/id_stage_ext.sv
// id_ext: 16-to-32 bit immediate extender (zero, sign or upper-half placement)
module id_ext
   import id_stage_pkg::*;
(
   input  logic [15:0] imm16,
   input  ext_op_e     ext_op,
   output logic [31:0] imm32
);
   always_comb
      imm32 = ext_op == EXT_ZERO ? {16'b0, imm16} :
              ext_op == EXT_LUI  ? {imm16, 16'b0} : {{16{imm16[15]}}, imm16};
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage resolving branches/jumps in ID and owning the ID/EX register.
// Defining ID_BRANCH_STAT_EN adds saturating taken-branch and jump counters.
module id_stage
   import id_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_pc_4,
   input  logic [31:0] id_instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        stall,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic        branch,
   output logic        jump,
   output logic [31:0] branch_addr32,
   output logic [31:0] jump_addr32,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_pc_8,
   output logic [31:0] ex_instr,
   output logic [31:0] ex_rs_data,
   output logic [31:0] ex_rt_data,
   output logic [31:0] ex_imm32,
   output logic [4:0]  ex_wr_addr,
   output logic        ex_wr_en
`ifdef ID_BRANCH_STAT_EN
   ,
   output logic [31:0] stat_branch_taken,
   output logic [31:0] stat_jump
`endif
);
   logic [5:0] op, funct;
   logic is_beq, is_bne, is_j, is_jal, is_jr, is_rtype, writes_rt;
   logic [4:0] wr_addr;
   logic [31:0] imm32, sext32;
   ext_op_e ext_op;

   always_comb begin
      op = id_instr[31:26];
      funct = id_instr[5:0];
      rs_addr = id_instr[25:21];
      rt_addr = id_instr[20:16];
      is_rtype = op == OP_RTYPE;
      is_beq = op == OP_BEQ;
      is_bne = op == OP_BNE;
      is_j = op == OP_J;
      is_jal = op == OP_JAL;
      is_jr = is_rtype && funct == FUNCT_JR;
      writes_rt = op == OP_ORI || op == OP_LUI || op == OP_ADDI || op == OP_LW;
      ext_op = op == OP_ORI ? EXT_ZERO : op == OP_LUI ? EXT_LUI : EXT_SIGN;
      sext32 = {{16{id_instr[15]}}, id_instr[15:0]};
      branch_addr32 = id_pc_4 + {sext32[29:0], 2'b00};
      jump_addr32 = is_j || is_jal ? {id_pc[31:28], id_instr[25:0], 2'b00} : is_jr ? rs_data : 32'h0;
      branch = ((is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data)) && !stall && !reset;
      jump = (is_j || is_jal || is_jr) && !stall && !reset;
      wr_addr = is_rtype && !is_jr ? id_instr[15:11] : writes_rt ? id_instr[20:16] : is_jal ? RA_REG : 5'd0;
   end

   id_ext u_ext (.imm16(id_instr[15:0]), .ext_op(ext_op), .imm32(imm32));

   // A stall turns the ID/EX register into a bubble identical to the reset state
   always_ff @(posedge clk) begin
      if (reset || stall) begin
         ex_pc <= RESET_PC;
         ex_pc_8 <= RESET_PC + 32'd8;
         ex_instr <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm32 <= '0;
         ex_wr_addr <= '0;
         ex_wr_en <= 1'b0;
      end else begin
         ex_pc <= id_pc;
         ex_pc_8 <= id_pc_4 + 32'd4;
         ex_instr <= id_instr;
         ex_rs_data <= rs_data;
         ex_rt_data <= rt_data;
         ex_imm32 <= imm32;
         ex_wr_addr <= wr_addr;
         ex_wr_en <= wr_addr != 5'd0;
      end
   end

`ifdef ID_BRANCH_STAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branch_taken <= '0;
         stat_jump <= '0;
      end else begin
         if (branch && !(&stat_branch_taken)) stat_branch_taken <= stat_branch_taken + 32'd1;
         if (jump && !(&stat_jump)) stat_jump <= stat_jump + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed plus randomized checks of id_stage against a behavioural decode model.
// Also checks the statistics counters when ID_BRANCH_STAT_EN is defined.
module tb_id_stage;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
   logic [31:0] id_pc = 32'h0, id_pc_4 = 32'h4, id_instr = 32'h0, rs_data = 32'h0, rt_data = 32'h0;
   logic [4:0] rs_addr, rt_addr, ex_wr_addr;
   logic branch, jump, ex_wr_en;
   logic [31:0] branch_addr32, jump_addr32, ex_pc, ex_pc_8, ex_instr, ex_rs_data, ex_rt_data, ex_imm32;
`ifdef ID_BRANCH_STAT_EN
   logic [31:0] stat_branch_taken, stat_jump;
`endif
   int n_vec = 0, n_bad = 0;
   longint m_br = 0, m_jp = 0;

   id_stage dut (
      .clk(clk), .reset(reset), .id_pc(id_pc), .id_pc_4(id_pc_4), .id_instr(id_instr),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .branch(branch), .jump(jump), .branch_addr32(branch_addr32), .jump_addr32(jump_addr32),
      .ex_pc(ex_pc), .ex_pc_8(ex_pc_8), .ex_instr(ex_instr), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_imm32(ex_imm32), .ex_wr_addr(ex_wr_addr), .ex_wr_en(ex_wr_en)
`ifdef ID_BRANCH_STAT_EN
      , .stat_branch_taken(stat_branch_taken), .stat_jump(stat_jump)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One instruction through ID: check combinational outputs, then the ID/EX contents a cycle later
   task automatic step(input logic r, input logic s, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
      int op, fn, rs, rt, rd, dest;
      int imm;
      logic eb, ej, quiet;
      logic [31:0] ejt, eimm;
      reset = r; stall = s; id_pc = pc; id_pc_4 = pc + 4; id_instr = ins; rs_data = a; rt_data = b;
      op = int'(ins >> 26); fn = int'(ins & 32'h3F);
      rs = int'((ins >> 21) & 32'h1F); rt = int'((ins >> 16) & 32'h1F); rd = int'((ins >> 11) & 32'h1F);
      imm = int'(ins & 32'hFFFF);
      if (imm >= 32768) imm = imm - 65536;
      quiet = r || s;
      eb = !quiet && ((op == 4 && a == b) || (op == 5 && a != b));
      ej = !quiet && (op == 2 || op == 3 || (op == 0 && fn == 8));
      if (op == 2 || op == 3) ejt = (pc & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 4;
      else if (op == 0 && fn == 8) ejt = a;
      else ejt = 0;
      if (op == 13) eimm = ins & 32'hFFFF;
      else if (op == 15) eimm = (ins & 32'hFFFF) * 65536;
      else eimm = 32'(imm);
      if (op == 0) dest = fn == 8 ? 0 : rd;
      else if (op == 13 || op == 15 || op == 8 || op == 35) dest = rt;
      else if (op == 3) dest = 31;
      else dest = 0;
      #1;
      chk("rs_addr", 32'(rs_addr), 32'(rs));
      chk("rt_addr", 32'(rt_addr), 32'(rt));
      chk("branch", 32'(branch), 32'(eb));
      chk("jump", 32'(jump), 32'(ej));
      chk("branch_addr32", branch_addr32, pc + 4 + 32'(imm * 4));
      chk("jump_addr32", jump_addr32, ejt);
      if (eb && m_br < 64'hFFFF_FFFF) m_br++;
      if (ej && m_jp < 64'hFFFF_FFFF) m_jp++;
      if (r) begin m_br = 0; m_jp = 0; end
      @(posedge clk); #1;
      chk("ex_pc", ex_pc, quiet ? 32'h3000 : pc);
      chk("ex_pc_8", ex_pc_8, quiet ? 32'h3008 : pc + 8);
      chk("ex_instr", ex_instr, quiet ? 0 : ins);
      chk("ex_rs_data", ex_rs_data, quiet ? 0 : a);
      chk("ex_rt_data", ex_rt_data, quiet ? 0 : b);
      chk("ex_imm32", ex_imm32, quiet ? 0 : eimm);
      chk("ex_wr_addr", 32'(ex_wr_addr), quiet ? 0 : 32'(dest));
      chk("ex_wr_en", 32'(ex_wr_en), quiet ? 0 : 32'(dest != 0));
`ifdef ID_BRANCH_STAT_EN
      chk("stat_branch_taken", stat_branch_taken, 32'(m_br));
      chk("stat_jump", stat_jump, 32'(m_jp));
`endif
   endtask

   initial begin
      logic [5:0] ops [11];
      ops = '{6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h0D, 6'h0F, 6'h08, 6'h23, 6'h2B, 6'h00};
      @(posedge clk); #1;
      step(1, 0, 32'h3008, 32'h1022FFFE, 5, 5);
      step(1, 0, 32'h3008, 32'h1022FFFE, 5, 5);
      step(0, 0, 32'h3008, 32'h1022FFFE, 5, 5);
      chk("plan ex_instr beq", ex_instr, 32'h1022FFFE);
      step(0, 0, 32'h3008, 32'h1422FFFE, 5, 5);
      step(0, 0, 32'h3010, 32'h0C000C40, 0, 0);
      chk("plan ex_wr_addr jal", 32'(ex_wr_addr), 31);
      chk("plan ex_pc_8 jal", ex_pc_8, 32'h3018);
      step(0, 0, 32'h3014, 32'h03E00008, 32'h3018, 0);
`ifdef ID_BRANCH_STAT_EN
      chk("plan stat_branch_taken", stat_branch_taken, 1);
      chk("plan stat_jump", stat_jump, 2);
`endif
      step(0, 1, 32'h3008, 32'h1022FFFE, 5, 5);
      chk("plan bubble ex_pc", ex_pc, 32'h3000);
      step(0, 0, 32'h3008, 32'h1022FFFE, 5, 5);
      step(0, 0, 32'h3020, 32'h3421FFFF, 0, 0);
      chk("plan ori imm", ex_imm32, 32'h0000FFFF);
      step(0, 0, 32'h3024, 32'h3C018000, 0, 0);
      chk("plan lui imm", ex_imm32, 32'h80000000);
      step(0, 0, 32'h3028, 32'h2000FFFF, 0, 0);
      chk("plan addi $0 wr_en", 32'(ex_wr_en), 0);
      for (int i = 0; i < 400; i++) begin
         int k;
         logic [31:0] ins, a, b;
         k = $urandom_range(0, 11);
         ins = $urandom;
         if (k < 11) ins[31:26] = ops[k];
         if (k == 0) ins[5:0] = ($urandom_range(0, 1) == 1) ? 6'h08 : 6'h21;
         a = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 3));
         b = $urandom_range(0, 1) == 0 ? a : $urandom;
         step($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, $urandom, ins, a, b);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
